// File: rtl/galaxian_audio_pkg.sv
// Shared types and widths for the Galaxian audio post-processing path.
// Also holds the DAC-word to signed-PCM encoding used by the output stage.
package galaxian_audio_pkg;

  localparam int MIX_W = 11;
  localparam int PCM_W = 16;
  localparam int CH_W  = 8;

  typedef enum logic [1:0] {
    MUTED,
    RAMP_UP,
    RUN,
    RAMP_DOWN
  } gain_state_t;

  // Offset-binary to two's complement, with the top DAC bits repeated into the LSBs
  function automatic logic [PCM_W-1:0] dac_to_pcm(input logic [MIX_W-1:0] dac);
    return {~dac[MIX_W-1], dac[MIX_W-2:0], dac[MIX_W-2:MIX_W-6]};
  endfunction

endpackage

// File: rtl/audio_lpf1.sv
// One-pole low-pass filter: y += (x - y) * 2^-SHIFT, with SHIFT fractional
// accumulator bits so small steps are not lost. SHIFT=0 passes the input straight through.
module audio_lpf1 #(
  parameter int WIDTH = 11,
  parameter int SHIFT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  localparam int ACC_W = WIDTH + SHIFT;

  logic        [ACC_W-1:0] y_q;
  logic        [ACC_W-1:0] target;
  logic signed [ACC_W:0]   diff;
  logic signed [ACC_W:0]   step;

  // One extra sign bit keeps the difference exact in both directions
  always_comb begin
    target = ACC_W'(in_data) << SHIFT;
    diff   = $signed({1'b0, target}) - $signed({1'b0, y_q});
    step   = diff >>> SHIFT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q <= ACC_W'($signed({1'b0, y_q}) + step);
      end
    end
  end

  assign out_data = y_q[ACC_W-1 -: WIDTH];

endmodule

// File: rtl/galaxian_audio_mix.sv
// Galaxian A/B/C mixer: 1:4:2 weighted sum, optional low-pass, click-free gain
// ramp, then registered DAC and PCM outputs three cycles after each sample strobe.
module galaxian_audio_mix
  import galaxian_audio_pkg::*;
#(
  parameter int FILT_SHIFT = 3,
  parameter int RAMP_BITS  = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_sample,
  input  logic [CH_W-1:0]  audio_a,
  input  logic [CH_W-1:0]  audio_b,
  input  logic [CH_W-1:0]  audio_c,
  input  logic             mute,
  output logic [MIX_W-1:0] dac_o,
  output logic [PCM_W-1:0] pcm_o,
  output logic             pcm_valid
);

  localparam int G_W    = RAMP_BITS + 1;
  localparam int PROD_W = MIX_W + G_W;
  localparam logic [G_W-1:0] G_ONE  = G_W'(1);
  localparam logic [G_W-1:0] G_ZERO = '0;
  localparam logic [G_W-1:0] G_MAX  = G_ONE << RAMP_BITS;

  logic [MIX_W-1:0]  mix_q;
  logic              mix_valid;
  logic [MIX_W-1:0]  filt_y;
  logic              filt_valid;
  gain_state_t       state;
  gain_state_t       state_next;
  logic [G_W-1:0]    g;
  logic [G_W-1:0]    g_next;
  logic [PROD_W-1:0] product;
  logic [MIX_W-1:0]  dac_next;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mix_q     <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= ce_sample;
      if (ce_sample) begin
        mix_q <= MIX_W'(audio_a) + (MIX_W'(audio_c) << 1) + (MIX_W'(audio_b) << 2);
      end
    end
  end

  audio_lpf1 #(
    .WIDTH (MIX_W),
    .SHIFT (FILT_SHIFT)
  ) u_lpf (
    .clk       (clk_sys),
    .reset     (reset),
    .in_data   (mix_q),
    .in_valid  (mix_valid),
    .out_data  (filt_y),
    .out_valid (filt_valid)
  );

  // Gain state and g only move when a sample reaches the gain stage
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= MUTED;
      g     <= '0;
    end else if (filt_valid) begin
      state <= state_next;
      g     <= g_next;
    end
  end

  always_comb begin
    state_next = state;
    g_next     = g;
    unique case (state)
      MUTED: begin
        g_next = G_ZERO;
        if (!mute) begin
          g_next     = G_ONE;
          state_next = (g_next == G_MAX) ? RUN : RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (mute) begin
          state_next = RAMP_DOWN;
        end else begin
          if (g < G_MAX) begin
            g_next = g + G_ONE;
          end
          if (g_next == G_MAX) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        g_next = G_MAX;
        if (mute) begin
          g_next     = G_MAX - G_ONE;
          state_next = (g_next == G_ZERO) ? MUTED : RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        if (!mute) begin
          state_next = RAMP_UP;
        end else begin
          if (g != G_ZERO) begin
            g_next = g - G_ONE;
          end
          if (g_next == G_ZERO) begin
            state_next = MUTED;
          end
        end
      end
      default: begin
        state_next = MUTED;
        g_next     = G_ZERO;
      end
    endcase
  end

  // The product uses g as it stood before this sample's update
  always_comb begin
    product  = PROD_W'(filt_y) * PROD_W'(g);
    dac_next = MIX_W'(product >> RAMP_BITS);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dac_o     <= '0;
      pcm_o     <= dac_to_pcm('0);
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= filt_valid;
      if (filt_valid) begin
        dac_o <= dac_next;
        pcm_o <= dac_to_pcm(dac_next);
      end
    end
  end

endmodule

// File: tb/tb_galaxian_audio_mix.sv
// Directed bench for galaxian_audio_mix: one unfiltered and one filtered instance
// share stimulus; outputs are collected on every pcm_valid and compared to hand values.
module tb_galaxian_audio_mix;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [7:0]  a, b, c;
  logic        mute;
  logic [10:0] dac0, dac3;
  logic [15:0] pcm0, pcm3;
  logic        valid0, valid3;

  int nVectors = 0;
  int nMiscompares = 0;
  int q0[$];
  int q3[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    int         expDac;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  galaxian_audio_mix #(.FILT_SHIFT(0), .RAMP_BITS(8)) dut0 (
    .clk_sys(clk), .reset(reset), .ce_sample(ce),
    .audio_a(a), .audio_b(b), .audio_c(c), .mute(mute),
    .dac_o(dac0), .pcm_o(pcm0), .pcm_valid(valid0)
  );

  galaxian_audio_mix #(.FILT_SHIFT(3), .RAMP_BITS(8)) dut3 (
    .clk_sys(clk), .reset(reset), .ce_sample(ce),
    .audio_a(a), .audio_b(b), .audio_c(c), .mute(mute),
    .dac_o(dac3), .pcm_o(pcm3), .pcm_valid(valid3)
  );

  always @(negedge clk) begin
    if (valid0 === 1'b1) q0.push_back(int'(dac0));
    if (valid3 === 1'b1) q3.push_back(int'(dac3));
  end

  function automatic int pcmOf(input int d);
    return (((d ^ 1024) << 5) | ((d >> 5) & 31)) & 16'hFFFF;
  endfunction

  function automatic int at0(input int k);
    return (k < q0.size()) ? q0[k] : -1;
  endfunction

  function automatic int at3(input int k);
    return (k < q3.size()) ? q3[k] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] na, input logic [7:0] nb,
                               input logic [7:0] nc, input logic nce, input logic nmute);
    a    = na;
    b    = nb;
    c    = nc;
    ce   = nce;
    mute = nmute;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // period=1 gives back-to-back strobes; the trailing ticks drain the pipeline
  task automatic sendSamples(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      ce = 1'b1;
      tick();
      ce = 1'b0;
      repeat (period - 1) tick();
    end
    ce = 1'b0;
    repeat (5) tick();
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    int yq;
    int sz;
    int expv;

    vecs[0]  = '{8'd0,   8'd0,   8'd0,   0};
    vecs[1]  = '{8'd255, 8'd255, 8'd255, 1785};
    vecs[2]  = '{8'd1,   8'd0,   8'd0,   1};
    vecs[3]  = '{8'd0,   8'd1,   8'd0,   4};
    vecs[4]  = '{8'd0,   8'd0,   8'd1,   2};
    vecs[5]  = '{8'd4,   8'd255, 8'd0,   1024};
    vecs[6]  = '{8'd100, 8'd50,  8'd25,  350};
    vecs[7]  = '{8'd255, 8'd0,   8'd0,   255};
    vecs[8]  = '{8'd0,   8'd255, 8'd0,   1020};
    vecs[9]  = '{8'd0,   8'd0,   8'd255, 510};
    vecs[10] = '{8'd7,   8'd3,   8'd5,   29};

    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    doReset();
    checkOutput("reset dac_o", int'(dac0), 0);
    checkOutput("reset pcm_o", int'(pcm0), 16'h8000);
    checkOutput("reset pcm_valid", int'(valid0), 0);
    checkOutput("reset pcm_o filtered", int'(pcm3), 16'h8000);

    // Full-scale ramp from MUTED with exact first-sample latency
    q0.delete(); q3.delete();
    applyStimulus(8'd255, 8'd255, 8'd255, 1'b1, 1'b0);
    tick();
    checkOutput("latency +1 valid", int'(valid0), 0);
    tick();
    checkOutput("latency +2 valid", int'(valid0), 0);
    tick();
    checkOutput("latency +3 valid", int'(valid0), 1);
    checkOutput("latency +3 dac", int'(dac0), 0);
    repeat (297) tick();
    ce = 1'b0;
    repeat (5) tick();
    checkOutput("burst pulse count", q0.size(), 300);
    for (int k = 0; k < 300; k++) begin
      expv = (1785 * ((k < 256) ? k : 256)) >> 8;
      checkOutput($sformatf("full ramp sample %0d", k), at0(k), expv);
    end
    checkOutput("RUN pcm_o full scale", int'(pcm0), pcmOf(1785));

    // Passthrough in RUN; channels are scrambled right after the strobe
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, 1'b1, 1'b0);
      tick();
      applyStimulus(~vecs[i].a, ~vecs[i].b, ~vecs[i].c, 1'b0, 1'b0);
      repeat (4) tick();
      checkOutput($sformatf("vector %0d dac", i), int'(dac0), vecs[i].expDac);
      checkOutput($sformatf("vector %0d pcm", i), int'(pcm0), pcmOf(vecs[i].expDac));
    end

    // Filter step response in RUN: settle at zero, then jump to full scale
    applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    sendSamples(100, 1);
    checkOutput("filter settled at zero", int'(dac3), 0);
    q3.delete();
    applyStimulus(8'd255, 8'd255, 8'd255, 1'b0, 1'b0);
    sendSamples(60, 1);
    checkOutput("filter step first", at3(0), 223);
    checkOutput("filter step second", at3(1), 418);
    yq = 0;
    for (int k = 0; k < 60; k++) begin
      yq = yq + (((1785 <<< 3) - yq) >>> 3);
      checkOutput($sformatf("filter step sample %0d", k), at3(k), yq >> 3);
    end

    // Mute from RUN ramps to silence over 256 samples
    q0.delete();
    applyStimulus(8'd4, 8'd255, 8'd0, 1'b0, 1'b1);
    sendSamples(260, 1);
    for (int k = 0; k < 260; k++) begin
      expv = (k < 256) ? 4 * (256 - k) : 0;
      checkOutput($sformatf("ramp down sample %0d", k), at0(k), expv);
    end

    // Linear ramp up from MUTED with mix=1024
    q0.delete();
    mute = 1'b0;
    sendSamples(300, 1);
    for (int k = 0; k < 300; k++) begin
      expv = (k <= 256) ? 4 * k : 1024;
      checkOutput($sformatf("ramp up sample %0d", k), at0(k), expv);
    end

    // Unmute part-way down: g turns round at 100
    q0.delete();
    mute = 1'b1;
    sendSamples(156, 1);
    checkOutput("partial down last", at0(155), 4 * 101);
    q0.delete();
    mute = 1'b0;
    sendSamples(20, 1);
    checkOutput("turnaround sample 0", at0(0), 400);
    for (int k = 1; k < 20; k++) begin
      checkOutput($sformatf("turnaround sample %0d", k), at0(k), 4 * (99 + k));
    end

    // Sparse strobes: exactly one pulse each
    sz = q0.size();
    sendSamples(3, 1000);
    checkOutput("sparse pulse count", q0.size() - sz, 3);

    // Reset with a sample in flight and a strobe coincident with reset
    doReset();
    q0.delete();
    applyStimulus(8'd4, 8'd255, 8'd0, 1'b0, 1'b0);
    sendSamples(50, 1);
    checkOutput("pre-reset ramp g=49 sample", at0(49), 196);
    ce = 1'b1;
    tick();
    ce = 1'b0;
    tick();
    reset = 1'b1;
    ce = 1'b1;
    tick();
    checkOutput("mid reset pcm_valid", int'(valid0), 0);
    checkOutput("mid reset dac_o", int'(dac0), 0);
    checkOutput("mid reset pcm_o", int'(pcm0), 16'h8000);
    reset = 1'b0;
    ce = 1'b0;
    sz = q0.size();
    repeat (6) tick();
    checkOutput("no stale pulse", q0.size() - sz, 0);
    checkOutput("held dac_o after reset", int'(dac0), 0);
    q0.delete();
    sendSamples(5, 1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("restart ramp sample %0d", k), at0(k), 4 * k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
